uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command-frame controller behind the UART receiver. It consumes the receiver's byte stream (rx_data plus the rx_done strobe) and parses fixed 4-byte frames: SYNC, ADDR, DATA, CHK. Each valid frame becomes a single-cycle register write on a simple configuration bus. It also detects checksum errors and inter-byte timeouts. It sits between uart_rx and the design's control/status registers.

Parameters:
CLK_FREQ, 10000000, system clock frequency in Hz.
BAUDRATE, 115200, UART line rate in baud; must match the receiver instance.
TIMEOUT_BYTES, 4, allowed gap between frame bytes, measured in 10-bit character times.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
rx_data  input  8  received byte from uart_rx; valid when rx_done is high.
rx_done  input  1  byte-complete strobe from uart_rx.
reg_wr_en  output  1  one-cycle register write strobe.
reg_addr  output  8  write address; valid while reg_wr_en is high.
reg_wdata  output  8  write data; valid while reg_wr_en is high.
err_chk  output  1  one-cycle pulse on a checksum mismatch.
err_timeout  output  1  one-cycle pulse on an inter-byte timeout.
busy  output  1  high while a frame is in progress (any state except IDLE).
frame_cnt  output  8  count of good frames; wraps from 255 to 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; internal addr/data/timer/rx_done_q cleared.
- Byte accept: accept = rx_done & ~rx_done_q, where rx_done_q is rx_done registered. A level held for N cycles counts as one byte.
- localparam TIMEOUT_CYCLES = TIMEOUT_BYTES*10*CLK_FREQ/BAUDRATE, integer division (3472 at defaults). Timer is 24 bits.
- States:
  - IDLE: on accept with rx_data==SYNC_BYTE -> ADDR. Any other byte is silently dropped.
  - ADDR: on accept, latch addr=rx_data -> DATA.
  - DATA: on accept, latch data=rx_data -> CHK.
  - CHK: on accept, if rx_data == (addr ^ data) then a good frame, else err_chk. Either way -> IDLE.
- SYNC_BYTE inside ADDR/DATA/CHK is treated as an ordinary payload value; there is no resync.
- Good frame: in the cycle after the accepting edge, reg_wr_en=1 with reg_addr=addr and reg_wdata=data, and frame_cnt increments. Latency is exactly 1 clk from the accept cycle.
- reg_addr and reg_wdata hold their last values when reg_wr_en is low. Consumers ignore them then.
- Bad checksum: err_chk=1 for one cycle, 1 clk after accept. No write occurs and frame_cnt is unchanged.
- Timer: cleared on every accept and held at 0 in IDLE. Otherwise it increments each cycle.
- Timeout: when the timer reaches TIMEOUT_CYCLES-1 with no accept in that cycle, err_timeout=1 for the next cycle, state -> IDLE, and the partial frame is discarded.
- Simultaneous accept and timer expiry: the accept wins; the byte is processed and the timer is cleared.
- All pulse outputs are registered and never high for more than one consecutive cycle.
- busy is combinational from state (state != IDLE).
- Reset mid-frame: the partial frame is discarded and no pulse is emitted. The next frame needs a fresh SYNC_BYTE.
- frame_cnt: modulo-256 wrap with no saturation.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, ADDR, DATA, CHK; 2-bit encoding);
  - SYNC_BYTE default;
  - function frame_chk(addr, data) returning addr ^ data;
  - function for the timeout-cycle calculation.
- Sub-module uart_frame_timer: 24-bit timer with clear/enable inputs and a one-cycle expired output.
- Parser FSM and output registers stay in uart_cmd_ctrl.

Test Plan:
- Frame A5 10 3C 2C, single-cycle rx_done per byte -> exactly one reg_wr_en pulse with addr=0x10 and wdata=0x3C, 1 clk after the 4th accept. frame_cnt goes 0->1, and err_chk/err_timeout stay low.
- Frame A5 10 3C 00 -> err_chk pulse 1 clk after the 4th accept. No reg_wr_en, frame_cnt unchanged, busy low afterwards.
- Bytes 00 FF 3C, then A5 20 55 75 -> only addr=0x20/wdata=0x55 is written. busy rises only after A5.
- A5 10, then no rx_done for 3472 cycles -> err_timeout pulse and return to IDLE. A following A5 01 02 03 writes addr=0x01/wdata=0x02.
- rx_done held high for 5 cycles on each byte of A5 07 08 0F -> one write (0x07/0x08) and no duplicate byte consumption.
- Reset asserted after A5 10, then released and 3C 2C sent -> no write and no error pulses. 256 good frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART command-frame controller.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned TIMER_W       = 24;

  function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
    return addr ^ data;
  endfunction

  // Character time is 10 bits (start + 8 data + stop).
  function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                 input int unsigned baudrate,
                                                 input int unsigned tbytes);
    longint unsigned num;
    num = 64'(tbytes) * 64'd10 * 64'(clk_freq);
    return 32'(num / 64'(baudrate));
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte gap timer; flags expiry combinationally so the parser can act in the same cycle.
module uart_frame_timer
  import uart_pkg::*;
#(
  parameter int unsigned LIMIT = 3472
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // A clear in the same cycle always beats expiry.
  assign expired_c_o = en_i & ~clr_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expired_c_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/ADDR/DATA/CHK frames from the UART byte stream into config-bus writes.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 10_000_000,
  parameter int unsigned BAUDRATE      = 115200,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, BAUDRATE, TIMEOUT_BYTES);

  state_e     state_q, state_d;
  logic       rx_done_q;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       reg_wr_en_q, reg_wr_en_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       err_chk_q, err_chk_d;
  logic       err_to_q, err_to_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic accept_c;
  logic expired_c;
  logic busy_c;

  // Rising edge of rx_done so a held strobe is consumed once.
  assign accept_c = rx_done & ~rx_done_q;
  assign busy_c   = (state_q != IDLE);

  uart_frame_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (accept_c | ~busy_c),
    .en_i        (busy_c),
    .expired_c_o (expired_c)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    reg_wr_en_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    err_chk_d   = 1'b0;
    err_to_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: if (accept_c && rx_data == SYNC_BYTE) state_d = ADDR;
      ADDR: if (accept_c) begin
        addr_d  = rx_data;
        state_d = DATA;
      end
      DATA: if (accept_c) begin
        data_d  = rx_data;
        state_d = CHK;
      end
      CHK: if (accept_c) begin
        if (rx_data == frame_chk(addr_q, data_q)) begin
          reg_wr_en_d = 1'b1;
          reg_addr_d  = addr_q;
          reg_wdata_d = data_q;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          err_chk_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Expiry is already masked by an accept in the same cycle.
    if (expired_c) begin
      err_to_d = 1'b1;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_done_q   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      reg_wr_en_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_done_q   <= rx_done;
      addr_q      <= addr_d;
      data_q      <= data_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      err_chk_q   <= err_chk_d;
      err_to_q    <= err_to_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign reg_wr_en   = reg_wr_en_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign err_chk     = err_chk_q;
  assign err_timeout = err_to_q;
  assign busy        = busy_c;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame-level queue model checked every cycle, plus vector table and corner sequences.
module tb_uart_cmd_ctrl;

  localparam int unsigned CLK_FREQ = 10_000_000;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned TOB      = 4;
  localparam int unsigned TO_CYC   = (TOB * 10 * CLK_FREQ) / BAUD;
  localparam logic [7:0]  SYNC     = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       reg_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       err_chk;
  logic       err_timeout;
  logic       busy;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUDRATE      (BAUD),
    .TIMEOUT_BYTES (TOB),
    .SYNC_BYTE     (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .reg_wr_en   (reg_wr_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Frame-level reference: a queue of bytes of the current frame and a gap counter.
  logic [7:0]  fq[$];
  int          gap = 0;
  bit          prev_done = 1'b0;
  int unsigned m_cnt = 0;
  bit          e_wr = 1'b0, e_chk = 1'b0, e_to = 1'b0;
  logic [7:0]  e_addr = 8'h00, e_data = 8'h00;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        fq.delete();
        gap = 0; prev_done = 1'b0; m_cnt = 0;
        e_wr = 1'b0; e_chk = 1'b0; e_to = 1'b0;
      end else begin
        bit acc;
        acc = rx_done && !prev_done;
        prev_done = rx_done;
        e_wr = 1'b0; e_chk = 1'b0; e_to = 1'b0;
        if (acc) begin
          gap = 0;
          if (fq.size() != 0 || rx_data == SYNC) fq.push_back(rx_data);
          if (fq.size() == 4) begin
            if ((fq[1] ^ fq[2]) == fq[3]) begin
              e_wr = 1'b1; e_addr = fq[1]; e_data = fq[2];
              m_cnt = (m_cnt + 1) % 256;
            end else begin
              e_chk = 1'b1;
            end
            fq.delete();
          end
        end else if (fq.size() != 0) begin
          gap++;
          if (gap >= int'(TO_CYC)) begin
            e_to = 1'b1;
            fq.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison and pulse tallies used by the directed sequences.
  int         n_wr = 0, n_chk = 0, n_to = 0;
  logic [7:0] last_addr = 8'h00, last_data = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cyc_wr_en", 32'(reg_wr_en), 32'(e_wr));
        check("cyc_err_chk", 32'(err_chk), 32'(e_chk));
        check("cyc_err_timeout", 32'(err_timeout), 32'(e_to));
        check("cyc_busy", 32'(busy), 32'(fq.size() != 0));
        check("cyc_frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        if (e_wr) begin
          check("cyc_reg_addr", 32'(reg_addr), 32'(e_addr));
          check("cyc_reg_wdata", 32'(reg_wdata), 32'(e_data));
        end
      end
      if (reg_wr_en) begin
        n_wr++; last_addr = reg_addr; last_data = reg_wdata;
      end
      if (err_chk) n_chk++;
      if (err_timeout) n_to++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int g);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0][7:0] b;
    int              hold;
    bit              wr;
    logic [7:0]      addr;
    logic [7:0]      data;
    bit              chk;
  } vec_t;

  vec_t vt[7];

  initial begin
    int wr0, chk0, to0;
    logic [7:0] cnt0;
    int n;
    logic [7:0] a, d;

    vt[0] = '{32'hA5103C2C, 1, 1'b1, 8'h10, 8'h3C, 1'b0};
    vt[1] = '{32'hA5103C00, 1, 1'b0, 8'h00, 8'h00, 1'b1};
    vt[2] = '{32'hA507080F, 5, 1'b1, 8'h07, 8'h08, 1'b0};
    vt[3] = '{32'hA5205575, 2, 1'b1, 8'h20, 8'h55, 1'b0};
    vt[4] = '{32'hA5A501A4, 1, 1'b1, 8'hA5, 8'h01, 1'b0};
    vt[5] = '{32'hA510A5B5, 3, 1'b1, 8'h10, 8'hA5, 1'b0};
    vt[6] = '{32'hA5FFFF01, 1, 1'b0, 8'h00, 8'h00, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst_err_chk", 32'(err_chk), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      wr0 = n_wr; chk0 = n_chk; to0 = n_to; cnt0 = frame_cnt;
      for (int k = 3; k >= 0; k--) send_byte(vt[i].b[k], vt[i].hold, 2);
      settle();
      check($sformatf("vec%0d_wr", i), 32'(n_wr - wr0), 32'(vt[i].wr));
      check($sformatf("vec%0d_chk", i), 32'(n_chk - chk0), 32'(vt[i].chk));
      check($sformatf("vec%0d_to", i), 32'(n_to - to0), 32'd0);
      check($sformatf("vec%0d_cnt", i), 32'(frame_cnt), 32'(8'(cnt0 + 8'(vt[i].wr))));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      if (vt[i].wr) begin
        check($sformatf("vec%0d_addr", i), 32'(last_addr), 32'(vt[i].addr));
        check($sformatf("vec%0d_data", i), 32'(last_data), 32'(vt[i].data));
      end
    end

    // Junk before SYNC is dropped; busy rises only on SYNC
    wr0 = n_wr;
    send_byte(8'h00, 1, 1); #1 check("junk00_busy", 32'(busy), 32'd0);
    send_byte(8'hFF, 1, 1); #1 check("junkFF_busy", 32'(busy), 32'd0);
    send_byte(8'h3C, 1, 1); #1 check("junk3C_busy", 32'(busy), 32'd0);
    send_byte(SYNC, 1, 1);  #1 check("sync_busy", 32'(busy), 32'd1);
    send_byte(8'h20, 1, 1);
    send_byte(8'h55, 1, 1);
    send_byte(8'h75, 1, 1);
    settle();
    check("junk_wr_count", 32'(n_wr - wr0), 32'd1);
    check("junk_addr", 32'(last_addr), 32'h20);
    check("junk_data", 32'(last_data), 32'h55);

    // Inter-byte timeout, then a clean frame
    to0 = n_to;
    send_byte(SYNC, 1, 1);
    send_byte(8'h10, 1, 0);
    n = 0;
    while (!err_timeout && n < int'(TO_CYC) + 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_seen", 32'(err_timeout), 32'd1);
    @(negedge clk);
    #1;
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_count", 32'(n_to - to0), 32'd1);
    @(negedge clk);
    wr0 = n_wr;
    send_byte(SYNC, 1, 1); send_byte(8'h01, 1, 1); send_byte(8'h02, 1, 1); send_byte(8'h03, 1, 1);
    settle();
    check("post_to_wr", 32'(n_wr - wr0), 32'd1);
    check("post_to_addr", 32'(last_addr), 32'h01);
    check("post_to_data", 32'(last_data), 32'h02);

    // Accept arriving around the expiry cycle; the tie (3471) must be accepted
    for (int g = 3469; g <= 3472; g++) begin
      wr0 = n_wr; to0 = n_to;
      send_byte(SYNC, 1, g);
      send_byte(8'h11, 1, 1); send_byte(8'h22, 1, 1); send_byte(8'h33, 1, 1);
      settle();
      check($sformatf("edge%0d_wr", g), 32'(n_wr - wr0), (g == 3472) ? 32'd0 : 32'd1);
      check($sformatf("edge%0d_to", g), 32'(n_to - to0), (g == 3472) ? 32'd1 : 32'd0);
    end

    // Reset mid-frame discards the partial frame
    send_byte(SYNC, 1, 1);
    send_byte(8'h10, 1, 1);
    do_reset();
    wr0 = n_wr; chk0 = n_chk; to0 = n_to;
    send_byte(8'h3C, 1, 1);
    send_byte(8'h2C, 1, 1);
    settle();
    check("rstmid_wr", 32'(n_wr - wr0), 32'd0);
    check("rstmid_chk", 32'(n_chk - chk0), 32'd0);
    check("rstmid_to", 32'(n_to - to0), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_cnt", 32'(frame_cnt), 32'd0);

    // frame_cnt wraps after 256 good frames
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      send_byte(SYNC, 1, 1); send_byte(a, 1, 1); send_byte(d, 1, 1); send_byte(a ^ d, 1, 1);
      if (i == 254) begin
        settle();
        check("cnt_255", 32'(frame_cnt), 32'd255);
      end
    end
    settle();
    check("cnt_wrap", 32'(frame_cnt), 32'd0);

    // Randomised traffic against the model
    n = 0;
    for (int i = 0; i < 400; i++) begin
      int r, h, gg;
      r = int'($urandom_range(0, 9));
      h = int'($urandom_range(1, 4));
      gg = int'($urandom_range(0, 3));
      a = 8'($urandom); d = 8'($urandom);
      if (r <= 5) begin
        send_byte(SYNC, h, gg + 1); send_byte(a, h, gg); send_byte(d, h, gg + 1); send_byte(a ^ d, h, 1);
      end else if (r == 6) begin
        send_byte(SYNC, h, 1); send_byte(a, h, 1); send_byte(d, h, 1);
        send_byte(a ^ d ^ 8'($urandom_range(1, 255)), h, 1);
      end else if (r == 7) begin
        send_byte(8'($urandom), h, gg);
      end else begin
        send_byte(SYNC, h, 1); send_byte(a, h, 1);
        if (r == 9 && n < 3) begin
          n++;
          repeat (TO_CYC + 5) @(negedge clk);
        end
      end
    end
    repeat (TO_CYC + 10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
